// File: rtl/mux_nto1_pipe.sv
// N-to-1 multiplexer with a registered output stage, valid/ready handshake and a
// 2-entry skid buffer so ready_o stays registered while sustaining full throughput.
module mux_nto1_pipe #(
  parameter int SIZE   = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_IN*SIZE-1:0] data_i,
  input  logic [SEL_W-1:0]       select_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   flush_i,
  output logic [SIZE-1:0]        data_o,
  output logic                   valid_o,
  output logic                   sel_err_o,
  input  logic                   ready_i
);

  generate
    if (NUM_IN < 2 || NUM_IN > (1 << SEL_W)) begin : g_bad_cfg
      $fatal(1, "mux_nto1_pipe: NUM_IN must lie in 2..2**SEL_W");
    end
  endgenerate

  logic [SIZE-1:0] sel_data_s;
  logic            sel_hit_s;
  logic            sel_err_s;

  logic [SIZE-1:0] data_r;
  logic            err_r;
  logic            valid_r;
  logic [SIZE-1:0] skid_data_r;
  logic            skid_err_r;
  logic            ready_r;

  logic [SIZE-1:0] data_nxt_s;
  logic            err_nxt_s;
  logic            valid_nxt_s;
  logic [SIZE-1:0] skid_data_nxt_s;
  logic            skid_err_nxt_s;
  logic            ready_nxt_s;

  logic            skid_full_s;
  logic            in_s;
  logic            out_s;

  // AND-OR select; an index with no matching input yields zero data and the error flag.
  always_comb begin
    sel_data_s = {SIZE{1'b0}};
    sel_hit_s  = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      sel_data_s = sel_data_s | (data_i[k*SIZE +: SIZE] & {SIZE{select_i == SEL_W'(k)}});
      sel_hit_s  = sel_hit_s | (select_i == SEL_W'(k));
    end
    sel_err_s = ~sel_hit_s;
  end

  // The skid slot is occupied exactly when the stage refuses new input.
  assign skid_full_s = ~ready_r;
  assign in_s        = valid_i & ready_r;
  assign out_s       = valid_r & ready_i;

  // Next-state for main register and skid slot; every branch defaults to hold.
  always_comb begin
    data_nxt_s      = data_r;
    err_nxt_s       = err_r;
    valid_nxt_s     = valid_r;
    skid_data_nxt_s = skid_data_r;
    skid_err_nxt_s  = skid_err_r;
    ready_nxt_s     = ready_r;
    if (flush_i) begin
      data_nxt_s  = {SIZE{1'b0}};
      err_nxt_s   = 1'b0;
      valid_nxt_s = 1'b0;
      ready_nxt_s = 1'b1;
    end else if (skid_full_s) begin
      if (out_s) begin
        data_nxt_s  = skid_data_r;
        err_nxt_s   = skid_err_r;
        valid_nxt_s = 1'b1;
        ready_nxt_s = 1'b1;
      end else begin
        valid_nxt_s = 1'b1;
      end
    end else if (!valid_r || out_s) begin
      if (in_s) begin
        data_nxt_s  = sel_data_s;
        err_nxt_s   = sel_err_s;
        valid_nxt_s = 1'b1;
      end else begin
        valid_nxt_s = 1'b0;
      end
    end else begin
      // Main register stalled: a new item parks in the skid slot.
      if (in_s) begin
        skid_data_nxt_s = sel_data_s;
        skid_err_nxt_s  = sel_err_s;
        ready_nxt_s     = 1'b0;
      end else begin
        ready_nxt_s = 1'b1;
      end
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_r      <= {SIZE{1'b0}};
      err_r       <= 1'b0;
      valid_r     <= 1'b0;
      skid_data_r <= {SIZE{1'b0}};
      skid_err_r  <= 1'b0;
      ready_r     <= 1'b1;
    end else begin
      data_r      <= data_nxt_s;
      err_r       <= err_nxt_s;
      valid_r     <= valid_nxt_s;
      skid_data_r <= skid_data_nxt_s;
      skid_err_r  <= skid_err_nxt_s;
      ready_r     <= ready_nxt_s;
    end
  end

  assign data_o    = data_r;
  assign sel_err_o = err_r;
  assign valid_o   = valid_r;
  assign ready_o   = ready_r;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Scoreboard bench for mux_nto1_pipe: a 4-input instance streamed with directed and
// random traffic, plus a 3-input instance exercising the out-of-range select.
module tb_mux_nto1_pipe;

  logic clk = 1'b0;
  logic rst;

  logic [127:0] data0;
  logic [1:0]   sel0;
  logic         valid0, flush0, rdy_in0;
  logic         ready_o0, valid_o0, err_o0;
  logic [31:0]  data_o0;

  logic [95:0]  data1;
  logic [1:0]   sel1;
  logic         valid1;
  logic         ready_o1, valid_o1, err_o1;
  logic [31:0]  data_o1;

  logic [32:0]  exp_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  int           n_acc    = 0;
  bit           zero_pend = 1'b0;

  always #5 clk = ~clk;

  mux_nto1_pipe #(.SIZE(32), .NUM_IN(4), .SEL_W(2)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .data_i(data0), .select_i(sel0), .valid_i(valid0),
    .ready_o(ready_o0), .flush_i(flush0), .data_o(data_o0), .valid_o(valid_o0),
    .sel_err_o(err_o0), .ready_i(rdy_in0)
  );

  mux_nto1_pipe #(.SIZE(32), .NUM_IN(3), .SEL_W(2)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .data_i(data1), .select_i(sel1), .valid_i(valid1),
    .ready_o(ready_o1), .flush_i(1'b0), .data_o(data_o1), .valid_o(valid_o1),
    .sel_err_o(err_o1), .ready_i(1'b1)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [32:0] model_sel(input logic [127:0] d, input logic [1:0] s, input int n);
    logic [31:0] w;
    if (int'(s) < n) begin
      w = d[s*32 +: 32];
      return {1'b0, w};
    end else begin
      return {1'b1, 32'h0};
    end
  endfunction

  // Check u_dut4 against the queue model at the falling edge, then advance one clock.
  task automatic cycle();
    bit acc, xfer;
    @(negedge clk);
    check_eq("ready_o", ready_o0, exp_q.size() < 2);
    check_eq("valid_o", valid_o0, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check_eq("data_o", data_o0, exp_q[0][31:0]);
      check_eq("sel_err_o", err_o0, exp_q[0][32]);
    end
    if (zero_pend) begin
      check_eq("data_o_zero", data_o0, 64'h0);
      check_eq("sel_err_zero", err_o0, 64'h0);
      zero_pend = 1'b0;
    end
    acc  = valid0 && (exp_q.size() < 2);
    xfer = (exp_q.size() != 0) && rdy_in0;
    if (rst) begin
      exp_q.delete();
      zero_pend = 1'b1;
    end else begin
      if (xfer) void'(exp_q.pop_front());
      if (flush0) begin
        exp_q.delete();
        zero_pend = 1'b1;
      end else if (acc) begin
        exp_q.push_back(model_sel(data0, sel0, 4));
        n_acc++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s, input logic rdy);
    valid0 = 1'b1; sel0 = s; rdy_in0 = rdy;
    cycle();
  endtask

  task automatic idle(input logic rdy, input int n);
    valid0 = 1'b0; rdy_in0 = rdy;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int start;
    rst = 1'b1; data0 = 128'h0; sel0 = 2'd0; valid0 = 1'b0; flush0 = 1'b0; rdy_in0 = 1'b1;
    data1 = 96'h0; sel1 = 2'd0; valid1 = 1'b0;
    @(posedge clk); #1;
    cycle();
    rst = 1'b0;
    check_eq("rst_valid", valid_o0, 64'h0);
    check_eq("rst_ready", ready_o0, 64'h1);
    check_eq("rst_data", data_o0, 64'h0);

    // Stream: one item per cycle, ready_o must never drop.
    data0 = {32'h44, 32'h33, 32'h22, 32'h11};
    for (int s = 0; s < 4; s++) send(2'(s), 1'b1);
    idle(1'b1, 2);

    // Backpressure: second item lands in the skid slot.
    send(2'd2, 1'b0);
    send(2'd3, 1'b0);
    check_eq("bp_ready_low", ready_o0, 64'h0);
    check_eq("bp_hold", data_o0, 64'h33);
    idle(1'b0, 2);
    idle(1'b1, 3);

    // Flush with skid full and a new item offered in the same cycle.
    send(2'd2, 1'b0);
    send(2'd3, 1'b0);
    flush0 = 1'b1;
    send(2'd0, 1'b0);
    flush0 = 1'b0;
    check_eq("flush_valid", valid_o0, 64'h0);
    check_eq("flush_ready", ready_o0, 64'h1);
    idle(1'b1, 3);

    // Reset mid-stream: no effect until an edge samples it.
    send(2'd2, 1'b0);
    send(2'd3, 1'b0);
    valid0 = 1'b1; sel0 = 2'd1;
    rst = 1'b1;
    #1;
    check_eq("rst_no_edge_valid", valid_o0, 64'h1);
    check_eq("rst_no_edge_ready", ready_o0, 64'h0);
    cycle();
    rst = 1'b0;
    check_eq("rst_mid_valid", valid_o0, 64'h0);
    check_eq("rst_mid_ready", ready_o0, 64'h1);
    idle(1'b1, 2);

    // Out-of-range select on the 3-input instance.
    data1 = {32'hc3, 32'hb2, 32'ha1};
    valid1 = 1'b1; sel1 = 2'd3;
    cycle();
    check_eq("oor_valid", valid_o1, 64'h1);
    check_eq("oor_data", data_o1, 64'h0);
    check_eq("oor_err", err_o1, 64'h1);
    sel1 = 2'd0;
    cycle();
    check_eq("inr_valid", valid_o1, 64'h1);
    check_eq("inr_data", data_o1, 64'ha1);
    check_eq("inr_err", err_o1, 64'h0);
    valid1 = 1'b0;

    // Random valid/ready traffic over 1000 accepted items.
    start = n_acc;
    for (int c = 0; c < 20000 && (n_acc - start) < 1000; c++) begin
      data0   = {$urandom, $urandom, $urandom, $urandom};
      sel0    = 2'($urandom_range(0, 3));
      valid0  = ($urandom_range(0, 3) != 0);
      rdy_in0 = ($urandom_range(0, 3) != 0);
      cycle();
    end
    check_eq("rand_items_done", 64'(n_acc - start >= 1000), 64'h1);
    idle(1'b1, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
